// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the UART transmit controller.
//   tx_state_t  : frame-phase state encoding (IDLE, START, DATA, PARITY, STOP)
//   START_BIT   : line level driven during the start bit
//   STOP_BIT    : line level driven during the stop bit
//   IDLE_LEVEL  : line level while no frame is in progress
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: word handshake between the TX FIFO read logic and the
// transmit controller.
//   DATA_VALID : source has a word on P_DATA
//   P_DATA     : word to transmit
//   PAR_EN     : parity enable, sampled when the word is accepted
//   PAR_TYP    : parity type, sampled when the word is accepted
//   TX_READY   : controller can accept a word this cycle
// master = word source, slave = uart_tx_ctrl.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 16
);

  logic                  DATA_VALID;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_READY;

  modport master (
    output DATA_VALID,
    output P_DATA,
    output PAR_EN,
    output PAR_TYP,
    input  TX_READY
  );

  modport slave (
    input  DATA_VALID,
    input  P_DATA,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_READY
  );

endinterface

// File: rtl/uart_tx_bitcnt.sv
// uart_tx_bitcnt: data-bit counter for the transmit controller.
//   CLK  : bit clock
//   RST  : asynchronous active-low reset
//   clr  : reload the counter to zero (has priority over en)
//   en   : count up by one
//   last : counter currently equals LAST (final data bit of the frame)
module uart_tx_bitcnt #(
  parameter int WIDTH = 4,
  parameter int LAST  = 15
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + WIDTH'(1);
    end
  end

  assign last = (cnt_reg == WIDTH'(LAST));

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer.
// Accepts a word over the bus handshake, holds it for parity_calc, and
// shifts it onto the line LSB-first as start / data / [parity] / stop.
//   CLK          : bit clock, one serial bit per cycle
//   RST          : asynchronous active-low reset (aborts any frame)
//   bus          : word handshake (DATA_VALID, P_DATA, PAR_EN, PAR_TYP, TX_READY)
//   PARITY_BIT   : parity_out from parity_calc, sent during PARITY
//   DATA_LATCHED : held word, feeds parity_calc P_DATA
//   PAR_CALC_EN  : parity_calc compute strobe (START cycle)
//   PARITY_FLAG  : parity_calc output-load strobe (last data cycle)
//   PAR_TYP_OUT  : latched parity type for parity_calc
//   TX_OUT       : serial line
//   BUSY         : frame in progress (START, DATA, PARITY)
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_tx_ctrl_if.slave         bus,
  input  logic                  PARITY_BIT,
  output logic [DATA_WIDTH-1:0] DATA_LATCHED,
  output logic                  PAR_CALC_EN,
  output logic                  PARITY_FLAG,
  output logic                  PAR_TYP_OUT,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  tx_state_t             state_reg;
  logic [DATA_WIDTH-1:0] shift_data_reg;
  logic [DATA_WIDTH-1:0] data_latched_reg;
  logic                  par_en_reg;
  logic                  par_typ_reg;
  logic                  last_bit;
  logic                  tx_ready;
  logic                  accept;
  logic                  tx_out_next;

  // Ready in STOP as well as IDLE so a waiting word starts the next frame
  // straight after the stop bit.
  assign tx_ready     = (state_reg == IDLE) || (state_reg == STOP);
  assign accept       = bus.DATA_VALID && tx_ready;
  assign bus.TX_READY = tx_ready;

  // Counter is cleared during START, so it is zero on the first DATA cycle.
  uart_tx_bitcnt #(
    .WIDTH (CNT_W),
    .LAST  (DATA_WIDTH - 1)
  ) u_bitcnt (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (state_reg == START),
    .en   (state_reg == DATA),
    .last (last_bit)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg        <= IDLE;
      shift_data_reg   <= '0;
      data_latched_reg <= '0;
      par_en_reg       <= 1'b0;
      par_typ_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, STOP: begin
          if (accept) begin
            shift_data_reg   <= bus.P_DATA;
            data_latched_reg <= bus.P_DATA;
            par_en_reg       <= bus.PAR_EN;
            par_typ_reg      <= bus.PAR_TYP;
            state_reg        <= START;
          end else begin
            state_reg <= IDLE;
          end
        end
        START: begin
          state_reg <= DATA;
        end
        DATA: begin
          shift_data_reg <= {1'b0, shift_data_reg[DATA_WIDTH-1:1]};
          if (last_bit) begin
            state_reg <= par_en_reg ? PARITY : STOP;
          end
        end
        PARITY: begin
          state_reg <= STOP;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Line level comes from registered state only, except PARITY_BIT which is
  // itself a registered output of parity_calc.
  always_comb begin
    tx_out_next = IDLE_LEVEL;
    case (state_reg)
      START:   tx_out_next = START_BIT;
      DATA:    tx_out_next = shift_data_reg[0];
      PARITY:  tx_out_next = PARITY_BIT;
      STOP:    tx_out_next = STOP_BIT;
      default: tx_out_next = IDLE_LEVEL;
    endcase
  end

  assign TX_OUT       = tx_out_next;
  assign BUSY         = (state_reg == START) || (state_reg == DATA) ||
                        (state_reg == PARITY);
  assign PAR_CALC_EN  = (state_reg == START);
  // parity_calc loads its output on this edge, so PARITY_BIT is valid for
  // the whole PARITY cycle that follows.
  assign PARITY_FLAG  = (state_reg == DATA) && last_bit && par_en_reg;
  assign DATA_LATCHED = data_latched_reg;
  assign PAR_TYP_OUT  = par_typ_reg;

endmodule
